down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
// PURPOSE
//   Loadable synchronous down-counter/timer: counterpart to the team's ripple up-counter.
//   Counts a preset value down to zero and signals completion with a START/DONE handshake.
//   Used for timeouts and delay generation alongside the up-counting blocks.
//   All state updates on the FALLING edge of CLK, the same as the team's counters.
// PARAMETERS
//   WIDTH   4   count width in bits; the maximum count is 2^WIDTH-1
// PORTS
//   CLK        in   1      clock; state updates on the negedge
//   CLEAR_BAR  in   1      asynchronous active-low reset; clears all state immediately
//   LOAD       in   1      load LOAD_VAL into the count and reload registers
//   LOAD_VAL   in   WIDTH  preset value
//   START      in   1      begin countdown (sampled in IDLE only)
//   STOP       in   1      abort countdown (sampled in RUN only)
//   NUM        out  WIDTH  current count
//   BUSY       out  1      1 while in RUN
//   DONE       out  1      one-cycle pulse on reaching zero
// BEHAVIOUR
//   Reset (CLEAR_BAR=0, async): NUM=0, BUSY=0, DONE=0, reload_reg=0, state=IDLE.
//     While CLEAR_BAR=0, all inputs are ignored; the first active edge after release is normal.
//   All outputs are registered; DONE defaults to 0 on every edge unless set below.
//   FSM states: IDLE, RUN.
//   IDLE:
//     - LOAD=1: NUM<=LOAD_VAL, reload_reg<=LOAD_VAL.
//     - START=1: the start uses the post-LOAD value when LOAD and START are on the same edge.
//         If that value is !=0: go to RUN, BUSY<=1; NUM is not decremented on this edge.
//         If that value is ==0: DONE<=1 for one cycle, stay in IDLE, BUSY stays 0.
//     - STOP is ignored.
//   RUN, priority STOP > LOAD > decrement:
//     - STOP=1: go to IDLE, BUSY<=0, NUM holds, no DONE.
//     - LOAD=1: NUM<=LOAD_VAL, reload_reg<=LOAD_VAL, stay in RUN (restart).
//         If LOAD_VAL==0, apply the zero-reach rule below on this edge.
//     - Otherwise NUM<=NUM-1.
//     - Zero reach (NUM==1 decrementing to 0): DONE<=1, BUSY<=0, go to IDLE.
//     - START is ignored.
//   Latency: a start edge with value N gives DONE high after the Nth following negedge;
//     BUSY is high for exactly N cycles.
//   No wrap-around: NUM never decrements below 0.
//     A WIDTH-bit preset of 2^WIDTH-1 is valid and takes the full count.
//   Reset mid-RUN: returns immediately to the reset values; no DONE is produced.
// CONFIGURATION
//   AUTO_RELOAD_EN defined:
//     - On zero reach: NUM<=reload_reg, DONE<=1, stay in RUN, BUSY stays 1.
//     - The count repeats with a period of reload_reg cycles until STOP or reset.
//     - If reload_reg==0 at zero reach, the block falls back to the one-shot rule (go to IDLE).
//   AUTO_RELOAD_EN undefined:
//     - One-shot behaviour only; reload_reg may be omitted by synthesis.
// TESTING
//   1. Reset: CLEAR_BAR=0 mid-RUN at NUM=5 -> NUM=0, BUSY=0, DONE=0 immediately, without any clock edge.
//   2. One-shot: LOAD_VAL=4, LOAD+START on one edge -> BUSY for 4 cycles, NUM 4,3,2,1,0;
//      DONE pulses once when NUM becomes 0; state is IDLE afterwards.
//   3. Zero start: LOAD_VAL=0, LOAD+START -> DONE pulse next edge, BUSY stays 0, NUM=0.
//   4. Abort/restart: start at 9, STOP at NUM=6 -> NUM holds 6, BUSY=0, no DONE.
//      Then start at 9 again and pulse LOAD with LOAD_VAL=3 at NUM=7 -> counts 3,2,1,0, then DONE.
//   5. Max/no wrap (WIDTH=4): start at 15 -> 15 decrements, DONE once, NUM stays 0 (never 15).
//   6. AUTO_RELOAD_EN, LOAD_VAL=3: DONE every 3 cycles, NUM 3,2,1,0->3..., BUSY=1 throughout;
//      STOP -> IDLE with no further DONE.

Source files
------------

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter/timer with a start/done handshake.
// A preset is counted down to zero; busy is high while counting and done pulses
// for one cycle on reaching zero. All state changes on the falling clock edge.
// Optional feature: define AUTO_RELOAD_EN to reload the preset on zero reach and
// keep running until stop or reset; undefined gives one-shot operation.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_bar,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_ZERO = '0;
    localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] reload_reg, reload_n;
    logic [WIDTH-1:0] num_n;
    logic             busy_n;
    logic             done_n;
    logic [WIDTH-1:0] start_val;

    // State and registered outputs, updated on the falling edge, cleared asynchronously.
    always_ff @(negedge clk or negedge clear_bar) begin
        if (!clear_bar) begin
            state      <= IDLE;
            num        <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the values from before this edge, independent of statement order.
            state      <= state_n;
            num        <= num_n;
            reload_reg <= reload_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state and next-output logic; load/start/stop priorities resolved here.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a variable unassigned and no latch is inferred.
        state_n   = state;
        num_n     = num;
        reload_n  = reload_reg;
        busy_n    = busy;
        done_n    = 1'b0;
        start_val = load ? load_val : num;

        case (state)
            IDLE: begin
                if (load) begin
                    num_n    = load_val;
                    reload_n = load_val;
                end
                if (start) begin
                    if (start_val != COUNT_ZERO) begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                    end else begin
                        done_n  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (load) begin
                    num_n    = load_val;
                    reload_n = load_val;
                    // A restart with zero is an immediate zero reach; the new reload
                    // value is zero too, so this always ends the run.
                    if (load_val == COUNT_ZERO) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else if (num == COUNT_ONE) begin
                    done_n = 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (reload_reg != COUNT_ZERO) begin
                        num_n = reload_reg;
                    end else begin
                        num_n   = COUNT_ZERO;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
`else
                    num_n   = COUNT_ZERO;
                    busy_n  = 1'b0;
                    state_n = IDLE;
`endif
                end else if (num != COUNT_ZERO) begin
                    // The zero guard keeps the count from ever wrapping.
                    num_n = num - COUNT_ONE;
                end else begin
                    // Unreachable in normal use; leave RUN cleanly if it happens.
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: scoreboard bench for down_counter_timer (WIDTH=4).
// Stimulus drives inputs just after each rising edge and queues the hand-computed
// outputs expected after the following falling edge; a monitor pops and compares
// on the next rising edge.
module tb_down_counter_timer;

    localparam int WIDTH = 4;

    typedef struct {
        int num;
        int busy;
        int done;
    } exp_t;

    logic             clk;
    logic             clear_bar;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] num;
    logic             busy;
    logic             done;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   step_no;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clear_bar (clear_bar),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .stop      (stop),
        .num       (num),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // One cycle of stimulus plus the outputs expected after the next falling edge.
    task automatic step(input logic ld, input int lv, input logic st, input logic sp,
                        input int en, input int eb, input int ed);
        exp_t e;
        @(posedge clk);
        #1;
        load     = ld;
        load_val = WIDTH'(lv);
        start    = st;
        stop     = sp;
        e.num    = en;
        e.busy   = eb;
        e.done   = ed;
        exp_q.push_back(e);
        step_no++;
    endtask

    task automatic idle(input int en, input int eb, input int ed);
        step(1'b0, 0, 1'b0, 1'b0, en, eb, ed);
    endtask

    // Monitor: compares every queued expectation against the sampled outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("num",  32'(num),  32'(e.num));
                check("busy", 32'(busy), 32'(e.busy));
                check("done", 32'(done), 32'(e.done));
            end
        end
    end

    // Watchdog against an unexpected hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        step_no   = 0;
        clear_bar = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        start     = 1'b0;
        stop      = 1'b0;

        // Reset state, with active inputs ignored while clear_bar is low.
        idle(0, 0, 0);
        step(1'b1, 7, 1'b1, 1'b0, 0, 0, 0);
        idle(0, 0, 0);
        clear_bar = 1'b1;

        // Zero start: load 0 with start gives an immediate done pulse, no busy.
        step(1'b1, 0, 1'b1, 1'b0, 0, 0, 1);
        idle(0, 0, 0);
        // Stop is ignored in IDLE.
        step(1'b0, 0, 1'b0, 1'b1, 0, 0, 0);

`ifndef AUTO_RELOAD_EN
        // One-shot of 4: busy for four cycles, done once as num reaches 0.
        step(1'b1, 4, 1'b1, 1'b0, 4, 1, 0);
        idle(3, 1, 0);
        step(1'b0, 0, 1'b1, 1'b0, 2, 1, 0);   // start ignored in RUN
        idle(1, 1, 0);
        idle(0, 0, 1);
        idle(0, 0, 0);
        // Back in IDLE: a plain start with num=0 is a zero start.
        step(1'b0, 0, 1'b1, 1'b0, 0, 0, 1);
        idle(0, 0, 0);

        // Abort at 6: num holds, busy drops, no done.
        step(1'b1, 9, 1'b1, 1'b0, 9, 1, 0);
        idle(8, 1, 0);
        idle(7, 1, 0);
        idle(6, 1, 0);
        step(1'b1, 2, 1'b0, 1'b1, 6, 0, 0);   // stop beats load
        idle(6, 0, 0);
        // Restart at 9, reload 3 at num=7, count out.
        step(1'b1, 9, 1'b1, 1'b0, 9, 1, 0);
        idle(8, 1, 0);
        idle(7, 1, 0);
        step(1'b1, 3, 1'b0, 1'b0, 3, 1, 0);
        idle(2, 1, 0);
        idle(1, 1, 0);
        idle(0, 0, 1);
        idle(0, 0, 0);

        // Load of zero during RUN is an immediate zero reach.
        step(1'b1, 5, 1'b1, 1'b0, 5, 1, 0);
        idle(4, 1, 0);
        step(1'b1, 0, 1'b0, 1'b0, 0, 0, 1);
        idle(0, 0, 0);

        // Maximum preset: 15 decrements, one done, no wrap back to 15.
        step(1'b1, 15, 1'b1, 1'b0, 15, 1, 0);
        for (int k = 14; k >= 1; k--) idle(k, 1, 0);
        idle(0, 0, 1);
        idle(0, 0, 0);
        idle(0, 0, 0);
`else
        // Auto-reload of 3: done every third cycle, busy throughout, stop ends it.
        step(1'b1, 3, 1'b1, 1'b0, 3, 1, 0);
        idle(2, 1, 0);
        idle(1, 1, 0);
        idle(3, 1, 1);
        idle(2, 1, 0);
        idle(1, 1, 0);
        idle(3, 1, 1);
        idle(2, 1, 0);
        step(1'b0, 0, 1'b0, 1'b1, 2, 0, 0);
        idle(2, 0, 0);
        idle(2, 0, 0);
        idle(2, 0, 0);
`endif

        // Asynchronous clear mid-run at num=5: outputs clear with no clock edge.
        step(1'b1, 9, 1'b1, 1'b0, 9, 1, 0);
        idle(8, 1, 0);
        idle(7, 1, 0);
        idle(6, 1, 0);
        idle(5, 1, 0);
        @(posedge clk);
        #2;
        check("num_at_5", 32'(num), 32'd5);
        clear_bar = 1'b0;
        #1;
        check("clear_num",  32'(num),  32'd0);
        check("clear_busy", 32'(busy), 32'd0);
        check("clear_done", 32'(done), 32'd0);
        step(1'b1, 6, 1'b1, 1'b0, 0, 0, 0);
        idle(0, 0, 0);
        clear_bar = 1'b1;
        // First edge after release is normal.
        step(1'b1, 2, 1'b1, 1'b0, 2, 1, 0);
        idle(1, 1, 0);
`ifndef AUTO_RELOAD_EN
        idle(0, 0, 1);
`else
        idle(2, 1, 1);
`endif
        step(1'b0, 0, 1'b0, 1'b1, -1, -1, -1);
        void'(exp_q.pop_back());

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
